// File: rtl/saber_sprite_gen.sv
// saber_sprite_gen: hit-tests each scanned pixel against the saber sprite box,
// addresses the external sprite ROM and returns a registered colour index
// plus an opaque-pixel flag three clocks after the scan coordinates arrive.
// Optional build macro SABER_MIRROR_EN adds a per-frame horizontal flip input.
module saber_sprite_gen #(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int NUM_FRAMES  = 32,
  parameter int ADDR_W      = 15,
  parameter int CIDX_W      = 4,
  parameter int TRANSPARENT = 0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [5:0]        saber_state,
  input  logic [9:0]        SaberX,
  input  logic [9:0]        SaberY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
`ifdef SABER_MIRROR_EN
  input  logic              mirror,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [CIDX_W-1:0] rom_data,
  output logic              pixel_on,
  output logic [CIDX_W-1:0] pixel_cidx
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = $clog2(SPR_H);
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  logic          fclk_s1, fclk_s2, fclk_prev;
  logic          frame_edge;
  logic [FW-1:0] frame_l;
  logic [FW-1:0] frame_next;
  logic [9:0]    saber_x_l, saber_y_l;
  logic [XW-1:0] dx, dx_addr;
  logic [YW-1:0] dy;
  logic [10:0]   x_end, y_end;
  logic          hit_now;
  logic          hit0, hit1;
`ifdef SABER_MIRROR_EN
  logic          mirror_l;
`endif

  // Frame-edge detection, sprite offsets (only the low bits matter since the
  // sprite dimensions are powers of two) and 11-bit bound test so a box near
  // the right/bottom screen edge never wraps around to column/row 0.
  always_comb begin
    frame_edge = fclk_s2 & ~fclk_prev;
    frame_next = (int'(saber_state) >= NUM_FRAMES) ? '0 : saber_state[FW-1:0];
    dx         = DrawX[XW-1:0] - saber_x_l[XW-1:0];
    dy         = DrawY[YW-1:0] - saber_y_l[YW-1:0];
    x_end      = {1'b0, saber_x_l} + 11'(SPR_W);
    y_end      = {1'b0, saber_y_l} + 11'(SPR_H);
    hit_now    = (DrawX >= saber_x_l) && ({1'b0, DrawX} < x_end) &&
                 (DrawY >= saber_y_l) && ({1'b0, DrawY} < y_end);
`ifdef SABER_MIRROR_EN
    dx_addr    = mirror_l ? ~dx : dx;
`else
    dx_addr    = dx;
`endif
  end

  // Bring the asynchronous frame clock into this domain and remember its last value.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fclk_s1   <= 1'b0;
      fclk_s2   <= 1'b0;
      fclk_prev <= 1'b0;
    end else begin
      fclk_s1   <= frame_clk;
      fclk_s2   <= fclk_s1;
      fclk_prev <= fclk_s2;
    end
  end

  // Capture the animation frame and sprite position once per video frame.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frame_l   <= '0;
      saber_x_l <= '0;
      saber_y_l <= '0;
`ifdef SABER_MIRROR_EN
      mirror_l  <= 1'b0;
`endif
    end else if (frame_edge) begin
      frame_l   <= frame_next;
      saber_x_l <= SaberX;
      saber_y_l <= SaberY;
`ifdef SABER_MIRROR_EN
      mirror_l  <= mirror;
`endif
    end
  end

  // Stage 0: register the hit flag and, on a hit, the ROM address.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rom_addr <= '0;
      hit0     <= 1'b0;
    end else begin
      hit0 <= hit_now;
      if (hit_now) begin
        rom_addr <= ADDR_W'({frame_l, dy, dx_addr});
      end
    end
  end

  // Stage 1: carry the hit flag alongside the ROM read in flight.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hit1 <= 1'b0;
    end else begin
      hit1 <= hit0;
    end
  end

  // Stage 2: register the colour index and mask out transparent texels.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pixel_on   <= 1'b0;
      pixel_cidx <= '0;
    end else begin
      pixel_cidx <= rom_data;
      pixel_on   <= hit1 && (rom_data != CIDX_W'(TRANSPARENT));
    end
  end

endmodule

// File: tb/tb_saber_sprite_gen.sv
// tb_saber_sprite_gen: directed, table-driven bench for saber_sprite_gen with
// a synchronous 1-cycle sprite ROM model.
module tb_saber_sprite_gen;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [5:0]  saber_state;
  logic [9:0]  SaberX, SaberY, DrawX, DrawY;
  logic [14:0] rom_addr;
  logic [3:0]  rom_data = 4'h0;
  logic        pixel_on;
  logic [3:0]  pixel_cidx;
`ifdef SABER_MIRROR_EN
  logic        mirror;
`endif

  logic [3:0]  rom_mem [0:32767];

  int total = 0;
  int bad   = 0;

  saber_sprite_gen dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .saber_state (saber_state),
    .SaberX      (SaberX),
    .SaberY      (SaberY),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
`ifdef SABER_MIRROR_EN
    .mirror      (mirror),
`endif
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_on    (pixel_on),
    .pixel_cidx  (pixel_cidx)
  );

  // 50 MHz system clock
  always #10 Clk = ~Clk;

  // Synchronous sprite ROM, one clock of read latency
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic [5:0]  state;
    logic [9:0]  x;
    logic [9:0]  y;
    int          exp_addr;
    int          exp_on;
    int          exp_cidx;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] st, input logic [9:0] x, input logic [9:0] y);
    saber_state = st;
    DrawX       = x;
    DrawY       = y;
  endtask

  task automatic checkOutput(input string name, input int ea, input int eo, input int ec);
    chk({name, "_addr"}, int'(rom_addr), ea);
    chk({name, "_on"},   int'(pixel_on), eo);
    chk({name, "_cidx"}, int'(pixel_cidx), ec);
  endtask

  task automatic doFrame();
    frame_clk = 1'b1;
    repeat (4) tick();
    frame_clk = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    for (int a = 0; a < 32768; a++) rom_mem[a] = 4'hA;
    rom_mem[67]   = 4'h3;
    rom_mem[5185] = 4'h7;
    rom_mem[5120] = 4'h0;

    vecs[0] = '{6'd5, 10'd101, 10'd52, 5185, 1, 7};
    vecs[1] = '{6'd5, 10'd100, 10'd50, 5120, 0, 0};
    vecs[2] = '{6'd5, 10'd132, 10'd50, 5120, 0, 0};
    vecs[3] = '{6'd5, 10'd131, 10'd81, 6143, 1, 10};
    vecs[4] = '{6'd5, 10'd99,  10'd60, 6143, 0, 10};
    vecs[5] = '{6'd5, 10'd110, 10'd82, 6143, 0, 10};
    vecs[6] = '{6'd5, 10'd110, 10'd49, 6143, 0, 10};
    vecs[7] = '{6'd6, 10'd102, 10'd51, 5154, 1, 10};

    Reset = 1'b0; frame_clk = 1'b0;
    SaberX = 10'd0; SaberY = 10'd0;
`ifdef SABER_MIRROR_EN
    mirror = 1'b0;
`endif
    applyStimulus(6'd9, 10'd3, 10'd2);
    tick(); tick();
    checkOutput("reset", 0, 0, 0);

    // Release without any frame edge: frame 0, box at origin
    Reset = 1'b1;
    tick();
    chk("rel_addr", int'(rom_addr), 67);
    tick();
    chk("rel_on_early", int'(pixel_on), 0);
    tick();
    chk("rel_on", int'(pixel_on), 1);
    chk("rel_cidx", int'(pixel_cidx), 3);

    // Latch frame 5 at (100,50), then check exact latency
    applyStimulus(6'd5, 10'd600, 10'd400);
    SaberX = 10'd100; SaberY = 10'd50;
    doFrame();
    applyStimulus(6'd5, 10'd101, 10'd52);
    tick();
    chk("lat_addr", int'(rom_addr), 5185);
    chk("lat_on_t1", int'(pixel_on), 0);
    tick();
    chk("lat_on_t2", int'(pixel_on), 0);
    tick();
    chk("lat_on_t3", int'(pixel_on), 1);
    chk("lat_cidx_t3", int'(pixel_cidx), 7);

    // Table: hits, transparency, box edges, mid-frame state change
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].state, vecs[i].x, vecs[i].y);
      repeat (3) tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_on, vecs[i].exp_cidx);
    end

    // Next frame edge picks up state 6
    doFrame();
    checkOutput("frame6", 6178, 1, 10);

    // Right screen edge without wrap, out-of-range state latched as 0
    SaberX = 10'd1000;
    saber_state = 6'd40;
    doFrame();
    applyStimulus(6'd40, 10'd1023, 10'd52);
    repeat (3) tick();
    checkOutput("edge_hit", 87, 1, 10);
    applyStimulus(6'd40, 10'd0, 10'd52);
    repeat (3) tick();
    checkOutput("edge_nowrap", 87, 0, 10);

    // Frame edge coinciding with a hit: old frame first, new one next cycle
    applyStimulus(6'd3, 10'd1001, 10'd50);
    repeat (3) tick();
    frame_clk = 1'b1;
    tick(); tick(); tick();
    chk("same_cycle_old", int'(rom_addr), 1);
    tick();
    chk("same_cycle_new", int'(rom_addr), 3073);
    frame_clk = 1'b0;
    repeat (4) tick();
    chk("pre_reset_on", int'(pixel_on), 1);

    // Asynchronous reset mid-frame
    #5;
    Reset = 1'b0;
    #1;
    checkOutput("async_rst", 0, 0, 0);
    applyStimulus(6'd3, 10'd3, 10'd2);
    tick();
    Reset = 1'b1;
    tick();
    chk("rst2_addr", int'(rom_addr), 67);
    tick();
    chk("rst2_on_early", int'(pixel_on), 0);
    tick();
    chk("rst2_on", int'(pixel_on), 1);
    chk("rst2_cidx", int'(pixel_cidx), 3);

`ifdef SABER_MIRROR_EN
    SaberX = 10'd0; SaberY = 10'd0;
    applyStimulus(6'd0, 10'd0, 10'd0);
    mirror = 1'b1;
    doFrame();
    chk("mirror_on_addr", int'(rom_addr), 31);
    mirror = 1'b0;
    doFrame();
    chk("mirror_off_addr", int'(rom_addr), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
